// File: rtl/serial_add_sched_if.sv
// rtl/serial_add_sched_if.sv - request/response bundle for the bit-serial add scheduler
interface serial_add_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id,
    input  rsp_ready
  );
endinterface

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - round-robin scheduler sharing one 1-bit full adder across two requesters
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_add_sched_if.slave   bus,
  output logic                busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             id;
  logic             last_id;

  logic             grant;
  logic             accept;
  logic             ab_x;
  logic             s_bit;
  logic             c_bit;

  // Ties go to whichever requester was not served last.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_id;
    end
  end

  assign bus.req0_ready = (state == IDLE) && !grant && bus.req0_valid;
  assign bus.req1_ready = (state == IDLE) &&  grant && bus.req1_valid;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign ab_x  = a_sh[0] ^ b_sh[0];
  assign s_bit = ab_x ^ carry;
  assign c_bit = (a_sh[0] & b_sh[0]) | (ab_x & carry);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (count == LAST) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      count   <= '0;
      id      <= 1'b0;
      last_id <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= grant ? bus.req1_a   : bus.req0_a;
            b_sh  <= grant ? bus.req1_b   : bus.req0_b;
            carry <= grant ? bus.req1_cin : bus.req0_cin;
            id    <= grant;
            count <= '0;
          end
        end
        RUN: begin
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c_bit;
          // Wrap on the final bit so count stays within 0..WIDTH-1 for any WIDTH.
          count  <= (count == LAST) ? '0 : count + CW'(1);
        end
        RESP: begin
          if (bus.rsp_ready) begin
            last_id <= id;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_sum   = sum_sh;
  assign bus.rsp_cout  = carry;
  assign bus.rsp_id    = id;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - self-checking bench with a transaction-level model of the add scheduler
module tb_serial_add_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  serial_add_sched_if #(.WIDTH(W)) bus ();

  serial_add_sched #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding op at most, result due WIDTH edges after acceptance.
  int         cyc = 0;
  bit         m_pending = 0;
  bit         m_last = 1;
  bit         m_id = 0;
  logic [W:0] m_total = '0;
  int         m_due = 0;
  int         acc_ids[$];
  logic [W:0] rsp_tot[$];
  bit         rsp_ids[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit g, e_r0, e_r1, e_v;
    if (rst) begin
      m_pending = 0;
      m_last    = 1;
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_sum", bus.rsp_sum, 0);
      check("rst_rsp_cout", bus.rsp_cout, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
    end else begin
      e_v  = m_pending && (cyc >= m_due);
      e_r0 = 0;
      e_r1 = 0;
      if (!m_pending) begin
        g    = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        e_r0 = !g && bus.req0_valid;
        e_r1 = g && bus.req1_valid;
      end
      check("busy", busy, m_pending);
      check("rsp_valid", bus.rsp_valid, e_v);
      check("req0_ready", bus.req0_ready, e_r0);
      check("req1_ready", bus.req1_ready, e_r1);
      if (e_v) begin
        check("rsp_sum", bus.rsp_sum, m_total[W-1:0]);
        check("rsp_cout", bus.rsp_cout, m_total[W]);
        check("rsp_id", bus.rsp_id, m_id);
        if (bus.rsp_ready) begin
          m_last    = m_id;
          m_pending = 0;
          rsp_tot.push_back({bus.rsp_cout, bus.rsp_sum});
          rsp_ids.push_back(bus.rsp_id);
        end
      end else if (e_r0 || e_r1) begin
        m_pending = 1;
        m_id      = e_r1;
        m_total   = e_r1 ? (W+1)'(bus.req1_a) + (W+1)'(bus.req1_b) + (W+1)'(bus.req1_cin)
                         : (W+1)'(bus.req0_a) + (W+1)'(bus.req0_b) + (W+1)'(bus.req0_cin);
        m_due     = cyc + 1 + W;
        acc_ids.push_back(int'(e_r1));
      end
    end
  end

  task automatic send(input bit which, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin);
    bit got = 0;
    @(posedge clk); #1;
    if (which) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = 1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = 1;
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (which ? bus.req1_ready : bus.req0_ready) begin
        got = 1;
        break;
      end
    end
    check("accept_timeout", got, 1);
    @(posedge clk); #1;
    if (which) bus.req1_valid = 0;
    else       bus.req0_valid = 0;
  endtask

  task automatic get_rsp(input int hold);
    bit got = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
    end
    check("rsp_timeout", got, 1);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
  endtask

  task automatic expect_rsp(input string name, input logic [W:0] tot, input bit id);
    check({name, "_present"}, rsp_tot.size() > 0, 1);
    if (rsp_tot.size() > 0) begin
      check({name, "_total"}, rsp_tot.pop_front(), tot);
      check({name, "_id"}, rsp_ids.pop_front(), id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    bit got;
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 0;
    bus.rsp_ready  = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    send(0, 8'h5A, 8'h33, 0);
    @(posedge clk); #1;
    bus.req0_a = 8'hFF; bus.req0_b = 8'hFF;
    get_rsp(0);
    expect_rsp("single", 9'h08D, 0);

    send(0, 8'h00, 8'h00, 1);
    get_rsp(0);
    expect_rsp("zero_cin", 9'h001, 0);
    send(1, 8'hFF, 8'h01, 1);
    get_rsp(0);
    expect_rsp("overflow", 9'h101, 1);

    @(posedge clk); #1;
    base = acc_ids.size();
    bus.rsp_ready = 1;
    bus.req0_a = 8'h10; bus.req0_b = 8'h20; bus.req0_cin = 0; bus.req0_valid = 1;
    bus.req1_a = 8'h80; bus.req1_b = 8'h80; bus.req1_cin = 0; bus.req1_valid = 1;
    got = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (acc_ids.size() >= base + 4) begin
        got = 1;
        break;
      end
    end
    check("fair_timeout", got, 1);
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    got = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1;
        break;
      end
    end
    check("fair_drain_timeout", got, 1);
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    for (int k = 0; k < 4; k++) begin
      check("fair_grant_order", (acc_ids.size() > base + k) ? acc_ids[base + k] : -1, k % 2);
      expect_rsp("fair", (k % 2) ? 9'h100 : 9'h030, k[0]);
    end

    send(1, 8'h3C, 8'h44, 0);
    @(posedge clk); #1;
    bus.req0_a = 8'h01; bus.req0_b = 8'h02; bus.req0_cin = 0; bus.req0_valid = 1;
    get_rsp(5);
    got = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (bus.req0_ready) begin
        got = 1;
        break;
      end
    end
    check("bp_followup_accept", got, 1);
    @(posedge clk); #1;
    bus.req0_valid = 0;
    get_rsp(0);
    expect_rsp("backpressure", 9'h080, 1);
    expect_rsp("after_bp", 9'h003, 0);

    send(0, 8'hAA, 8'h55, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_sum", bus.rsp_sum, 0);
    check("abort_rsp_cout", bus.rsp_cout, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (12) @(posedge clk);
    check("abort_no_rsp", rsp_tot.size(), 0);

    send(0, 8'h0F, 8'h01, 0);
    get_rsp(0);
    expect_rsp("post_abort", 9'h010, 0);

    repeat (3) @(posedge clk);
    check("rsp_queue_empty", rsp_tot.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Two-requester scheduler that shares one 1-bit full adder, built from XOR/AND gates.
- Performs WIDTH-bit additions bit-serially, LSB first, with a carry flip-flop.
- Arbitrates round-robin between two request ports and returns each result on a single response port tagged with the requester ID.
- Sits between the pin-level top wrapper and the 1-bit adder datapath.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal values 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 accepted this cycle when valid&&ready.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_cin  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  WIDTH  sum bits.
- rsp_cout  output  1  final carry-out.
- rsp_id  output  1  requester that owns the result.
- busy  output  1  high in RUN or RESP.

Behaviour:
- Reset (asynchronous, any state) forces:
  - state=IDLE; rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0;
  - operand shift registers, carry and bit counter = 0;
  - last_id=1, so requester 0 wins the first tie.
- Reset during RUN or RESP aborts the operation; no response is ever produced for it.
- FSM has three states: IDLE, RUN, RESP.
- IDLE, arbitration (combinational, re-evaluated every cycle):
  - grant = the only valid requester;
  - if both are valid, grant = !last_id;
  - reqX_ready = (state==IDLE) && grant==X && reqX_valid. The ungranted port sees ready=0.
  - Requesters may drop valid before acceptance; no state changes.
- IDLE, on handshake:
  - latch a, b, cin and id=grant;
  - carry<=cin, count<=0, state<=RUN.
- RUN, each cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry;
  - c = (a_sh[0]&b_sh[0]) | ((a_sh[0]^b_sh[0])&carry);
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry<=c; count<=count+1.
  - When count==WIDTH-1, the same edge goes to RESP.
- RESP:
  - rsp_valid=1; rsp_sum=sum_sh, rsp_cout=carry, rsp_id=id, all held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: last_id<=id, rsp_valid<=0, state<=IDLE.
  - No new request is accepted on the response edge.
- Latency: rsp_valid rises exactly WIDTH rising edges after the accepting edge.
- Minimum issue interval: WIDTH+2 cycles per operation.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, exact, WIDTH+1 bits; wrap shows only as cout=1.
- count is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- Request operand inputs are ignored outside the accepting cycle; changing them mid-RUN has no effect.
- busy = (state!=IDLE).

Test Plan (WIDTH=8):
- Reset: assert rst mid-simulation with no clock edge → rsp_valid=0, rsp_sum=0x00, rsp_cout=0, busy=0, both ready=0 until a valid is seen.
- Single add: req0 a=0x5A b=0x33 cin=0 → req0_ready=1 for one cycle; rsp_valid exactly 8 edges later; sum=0x8D cout=0 id=0.
- Overflow: req1 a=0xFF b=0x01 cin=1 → sum=0x01 cout=1 id=1; also check a=0x00 b=0x00 cin=1 → sum=0x01 cout=0.
- Fairness: both requesters held valid for four operations (req0 a=0x10 b=0x20, req1 a=0x80 b=0x80).
  - Grant order must be 0,1,0,1.
  - Results: sum=0x30 cout=0 id=0, and sum=0x00 cout=1 id=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_sum, rsp_cout and rsp_id stay stable; both req_ready stay 0.
  - After the handshake, state is IDLE on the next cycle.
- Abort: assert rst 3 cycles into RUN → immediate IDLE, busy=0, no rsp_valid pulse.
  - Next request a=0x0F b=0x01 cin=0 → sum=0x10 cout=0.
